bsg_nonsynth_dramsim3_ch_arbiter: RTL and testbench

Round-robin arbiter that shares the DRAMSim3 channel request port among `num_clients_p` requesters in the nonsynthesizable memory test harness. It decodes the target channel from each request's global address according to `address_mapping_p`, limits outstanding reads per channel, and presents one registered request per cycle to the channel-side interface.

---
 rtl/bsg_nonsynth_dramsim3_ch_arbiter.sv | 144 ++++++++++++++
 tb/tb_bsg_nonsynth_dramsim3_ch_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_nonsynth_dramsim3_ch_arbiter.sv
// bsg_nonsynth_dramsim3_ch_arbiter: round-robin arbiter sharing one DRAMSim3 channel port, with per-channel read credits
package bsg_nonsynth_dramsim3_ch_arbiter_pkg;
  typedef enum logic [1:0] {e_ro_ra_bg_ba_co_ch, e_ro_ra_bg_ba_ch_co, e_ro_ch_ra_ba_bg_co} address_mapping_e;
endpackage

module bsg_nonsynth_dramsim3_ch_arbiter
  import bsg_nonsynth_dramsim3_ch_arbiter_pkg::*;
#(
  parameter int num_clients_p = 4,
  parameter int num_channels_p = 2,
  parameter int channel_addr_width_p = 20,
  parameter int data_width_p = 64,
  parameter int num_columns_p = 1024,
  parameter int num_ba_p = 4,
  parameter int num_bg_p = 4,
  parameter int num_ranks_p = 1,
  parameter address_mapping_e address_mapping_p = e_ro_ra_bg_ba_co_ch,
  parameter int max_out_reads_p = 4,
  localparam int lg_num_channels_lp = $clog2(num_channels_p),
  localparam int addr_width_lp = lg_num_channels_lp + channel_addr_width_p,
  localparam int ch_w_lp = num_channels_p == 1 ? 1 : lg_num_channels_lp,
  localparam int cl_w_lp = num_clients_p == 1 ? 1 : $clog2(num_clients_p)
) (
  input  logic                                         clk_i,
  input  logic                                         reset_i,
  input  logic [num_clients_p-1:0]                     v_i,
  input  logic [num_clients_p-1:0]                     write_not_read_i,
  input  logic [num_clients_p-1:0][addr_width_lp-1:0]  addr_i,
  input  logic [num_clients_p-1:0][data_width_p-1:0]   data_i,
  output logic [num_clients_p-1:0]                     yumi_o,
  output logic                                         v_o,
  output logic [ch_w_lp-1:0]                           ch_o,
  output logic [addr_width_lp-1:0]                     addr_o,
  output logic                                         write_not_read_o,
  output logic [data_width_p-1:0]                      data_o,
  output logic [cl_w_lp-1:0]                           client_o,
  input  logic                                         ready_i,
  input  logic                                         resp_v_i,
  input  logic [ch_w_lp-1:0]                           resp_ch_i
);
  localparam int byte_offset_width_lp = (data_width_p >> 3) == 1 ? 1 : $clog2(data_width_p >> 3);
  localparam int lg_num_columns_lp = $clog2(num_columns_p);
  localparam int lg_num_ba_lp = $clog2(num_ba_p);
  localparam int lg_num_bg_lp = $clog2(num_bg_p);
  localparam int lg_num_ranks_lp = $clog2(num_ranks_p);
  localparam int ch_base_lp = address_mapping_p == e_ro_ra_bg_ba_co_ch ? byte_offset_width_lp
    : address_mapping_p == e_ro_ra_bg_ba_ch_co ? byte_offset_width_lp + lg_num_columns_lp
    : byte_offset_width_lp + lg_num_columns_lp + lg_num_bg_lp + lg_num_ba_lp + lg_num_ranks_lp;
  localparam int cnt_w_lp = $clog2(max_out_reads_p + 1);
  localparam int n_cnt_lp = 1 << ch_w_lp;
  typedef enum logic {e_empty, e_full} state_e;
  state_e state_q, state_d;
  logic [cl_w_lp-1:0] rr_q, rr_d, win, client_q;
  logic [ch_w_lp-1:0] ch [num_clients_p];
  logic [ch_w_lp-1:0] win_ch, ch_q;
  logic [cnt_w_lp-1:0] cnt_q [n_cnt_lp];
  logic [cnt_w_lp-1:0] cnt_d [n_cnt_lp];
  logic [num_clients_p-1:0] elig;
  logic found, grant, rd_grant, win_wnr, wnr_q;
  logic [addr_width_lp-1:0] win_addr, addr_q;
  logic [data_width_p-1:0] win_data, data_q;

  if (address_mapping_p > e_ro_ch_ra_ba_bg_co) begin : g_bad_map
    $error("unsupported address_mapping_p");
  end

  for (genvar i = 0; i < num_clients_p; i++) begin : g_dec
    if (num_channels_p == 1) begin : g_one
      assign ch[i] = '0;
    end else begin : g_bits
      assign ch[i] = addr_i[i][ch_base_lp +: lg_num_channels_lp];
    end
    assign elig[i] = v_i[i] & (write_not_read_i[i] | (cnt_q[ch[i]] < cnt_w_lp'(max_out_reads_p)));
  end

  // walk offsets from far to near so the client closest to rr_q wins
  always_comb begin
    found = 1'b0;
    win = '0;
    win_ch = '0;
    win_wnr = 1'b0;
    win_addr = '0;
    win_data = '0;
    for (int k = num_clients_p - 1; k >= 0; k--) begin : l_rr
      automatic logic [cl_w_lp-1:0] j = cl_w_lp'((int'(rr_q) + k) % num_clients_p);
      if (elig[j]) begin
        found = 1'b1;
        win = j;
        win_ch = ch[j];
        win_wnr = write_not_read_i[j];
        win_addr = addr_i[j];
        win_data = data_i[j];
      end
    end
  end

  assign grant = found & (state_q == e_empty | ready_i) & ~reset_i;
  assign rd_grant = grant & ~win_wnr;
  assign yumi_o = grant ? (num_clients_p'(1) << win) : '0;
  assign state_d = grant ? e_full : ready_i ? e_empty : state_q;
  assign rr_d = grant ? (win == cl_w_lp'(num_clients_p - 1) ? '0 : win + 1'b1) : rr_q;

  always_comb begin
    for (int c = 0; c < n_cnt_lp; c++)
      cnt_d[c] = cnt_q[c] + cnt_w_lp'(rd_grant && win_ch == ch_w_lp'(c))
        - cnt_w_lp'(resp_v_i && resp_ch_i == ch_w_lp'(c) && cnt_q[c] != '0);
  end

  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state_q <= e_empty;
      rr_q <= '0;
      cnt_q <= '{default: '0};
      ch_q <= '0;
      addr_q <= '0;
      wnr_q <= 1'b0;
      data_q <= '0;
      client_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      cnt_q <= cnt_d;
      if (grant) begin
        ch_q <= win_ch;
        addr_q <= win_addr;
        wnr_q <= win_wnr;
        data_q <= win_data;
        client_q <= win;
      end
      for (int c = 0; c < n_cnt_lp; c++) begin
        if (resp_v_i && resp_ch_i == ch_w_lp'(c) && cnt_q[c] == '0)
          $error("read response on channel %0d with no outstanding reads", c);
        if (rd_grant && win_ch == ch_w_lp'(c) && cnt_q[c] == cnt_w_lp'(max_out_reads_p))
          $error("outstanding read count overflow on channel %0d", c);
      end
    end

  assign v_o = state_q == e_full;
  assign ch_o = ch_q;
  assign addr_o = addr_q;
  assign write_not_read_o = wnr_q;
  assign data_o = data_q;
  assign client_o = client_q;
endmodule

// File: tb/tb_bsg_nonsynth_dramsim3_ch_arbiter.sv
// tb_bsg_nonsynth_dramsim3_ch_arbiter: directed and randomized checks against a cycle-level reference model
module tb_bsg_nonsynth_dramsim3_ch_arbiter;
  import bsg_nonsynth_dramsim3_ch_arbiter_pkg::*;
  localparam int nc = 4, aw = 21, dw = 64;
  localparam int bo = $clog2(dw / 8);
  localparam int base [3] = '{bo, bo + $clog2(1024), bo + $clog2(1024) + $clog2(4) + $clog2(4) + $clog2(1)};

  logic clk = 1'b0, reset_i = 1'b1;
  logic [nc-1:0] v_i = '0, wnr_i = '0, yumi_o;
  logic [nc-1:0][aw-1:0] addr_i = '0;
  logic [nc-1:0][dw-1:0] data_i = '0;
  logic v_o, wnr_o, ch_o, ready_i = 1'b0, resp_v_i = 1'b0, resp_ch_i = 1'b0;
  logic [1:0] client_o;
  logic [aw-1:0] addr_o;
  logic [dw-1:0] data_o;
  int n_checks = 0, n_fail = 0;

  logic mv_i [3], my_o [3], mv_o [3], mch_o [3], mwnr_o [3], mcl_o [3];
  logic [aw-1:0] maddr_i [3], maddr_o [3];
  logic [dw-1:0] mdata_o [3];
  logic [dw-1:0] mdata_i = '0;

  // reference model state
  logic m_v = 1'b0, m_wnr = 1'b0, m_ch = 1'b0;
  int m_rr = 0, m_client = 0;
  int m_cnt [2] = '{0, 0};
  logic [aw-1:0] m_addr = '0;
  logic [dw-1:0] m_data = '0;

  always #5 clk = ~clk;

  bsg_nonsynth_dramsim3_ch_arbiter #(
    .num_clients_p(4), .num_channels_p(2), .channel_addr_width_p(20), .data_width_p(dw),
    .num_columns_p(1024), .num_ba_p(4), .num_bg_p(4), .num_ranks_p(1),
    .address_mapping_p(e_ro_ra_bg_ba_co_ch), .max_out_reads_p(2)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .write_not_read_i(wnr_i), .addr_i(addr_i),
    .data_i(data_i), .yumi_o(yumi_o), .v_o(v_o), .ch_o(ch_o), .addr_o(addr_o),
    .write_not_read_o(wnr_o), .data_o(data_o), .client_o(client_o), .ready_i(ready_i),
    .resp_v_i(resp_v_i), .resp_ch_i(resp_ch_i)
  );

  for (genvar g = 0; g < 3; g++) begin : g_map
    bsg_nonsynth_dramsim3_ch_arbiter #(
      .num_clients_p(1), .num_channels_p(2), .channel_addr_width_p(20), .data_width_p(dw),
      .num_columns_p(1024), .num_ba_p(4), .num_bg_p(4), .num_ranks_p(1),
      .address_mapping_p(address_mapping_e'(g)), .max_out_reads_p(4)
    ) u_map (
      .clk_i(clk), .reset_i(reset_i), .v_i(mv_i[g]), .write_not_read_i(1'b1), .addr_i(maddr_i[g]),
      .data_i(mdata_i), .yumi_o(my_o[g]), .v_o(mv_o[g]), .ch_o(mch_o[g]), .addr_o(maddr_o[g]),
      .write_not_read_o(mwnr_o[g]), .data_o(mdata_o[g]), .client_o(mcl_o[g]), .ready_i(1'b1),
      .resp_v_i(1'b0), .resp_ch_i(1'b0)
    );
  end

  function automatic int m_winner();
    if (reset_i || (m_v && !ready_i)) return -1;
    for (int k = 0; k < nc; k++) begin
      int i;
      i = (m_rr + k) % nc;
      if (v_i[i] && (wnr_i[i] || m_cnt[addr_i[i][bo]] < 2)) return i;
    end
    return -1;
  endfunction

  function automatic logic [nc-1:0] m_yumi();
    int w;
    w = m_winner();
    return w < 0 ? '0 : nc'(1 << w);
  endfunction

  task automatic tick();
    int w;
    w = m_winner();
    @(posedge clk);
    if (reset_i) begin
      m_v = 1'b0; m_rr = 0; m_cnt = '{0, 0};
    end else begin
      if (resp_v_i && m_cnt[resp_ch_i] > 0) m_cnt[resp_ch_i]--;
      if (w >= 0) begin
        m_v = 1'b1; m_client = w; m_addr = addr_i[w]; m_data = data_i[w];
        m_wnr = wnr_i[w]; m_ch = addr_i[w][bo]; m_rr = (w + 1) % nc;
        if (!wnr_i[w]) m_cnt[addr_i[w][bo]]++;
      end else if (ready_i) m_v = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    v_i = '1; wnr_i = '1; ready_i = 1'b1;
    for (int i = 0; i < nc; i++) begin addr_i[i] = aw'($urandom); data_i[i] = {$urandom, $urandom}; end
    @(negedge clk); @(negedge clk);
    n_checks += 7;
    if (yumi_o !== '0) begin n_fail++; $display("FAIL reset_yumi: got %b want 0", yumi_o); end
    if (v_o !== 1'b0) begin n_fail++; $display("FAIL reset_v: got %b want 0", v_o); end
    if (ch_o !== 1'b0) begin n_fail++; $display("FAIL reset_ch: got %b want 0", ch_o); end
    if (addr_o !== '0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", addr_o); end
    if (data_o !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", data_o); end
    if (client_o !== '0) begin n_fail++; $display("FAIL reset_client: got %0d want 0", client_o); end
    if (wnr_o !== 1'b0) begin n_fail++; $display("FAIL reset_wnr: got %b want 0", wnr_o); end
    v_i = '0;
    reset_i = 1'b0;
  endtask

  task automatic test_fairness();
    v_i = '1; wnr_i = '1; ready_i = 1'b1;
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < nc; i++) addr_i[i] = aw'($urandom);
      #1;
      n_checks += 2;
      if (yumi_o !== nc'(1 << (c % 4))) begin n_fail++; $display("FAIL fair_yumi c=%0d: got %b want %b", c, yumi_o, nc'(1 << (c % 4))); end
      if (v_o !== (c != 0)) begin n_fail++; $display("FAIL fair_v c=%0d: got %b want %b", c, v_o, c != 0); end
      if (c != 0) begin
        n_checks++;
        if (client_o !== 2'((c - 1) % 4)) begin n_fail++; $display("FAIL fair_client c=%0d: got %0d want %0d", c, client_o, (c - 1) % 4); end
      end
      tick();
    end
    v_i = '0;
    tick();
    n_checks++;
    if (v_o !== 1'b0) begin n_fail++; $display("FAIL fair_drain_v: got %b want 0", v_o); end
  endtask

  task automatic test_decode();
    logic [aw-1:0] a [3];
    logic [aw-1:0] dir [3] = '{21'h8, 21'h2000, 21'h60000};
    for (int n = 0; n < 6; n++) begin
      for (int g = 0; g < 3; g++) begin
        a[g] = n == 0 ? dir[g] : aw'($urandom);
        if (g == 2) a[g][base[2] + 1] = a[g][base[2]];
        maddr_i[g] = a[g];
        mv_i[g] = 1'b1;
      end
      tick();
      for (int g = 0; g < 3; g++) begin
        n_checks += 3;
        if (mv_o[g] !== 1'b1) begin n_fail++; $display("FAIL map%0d_v: got %b want 1", g, mv_o[g]); end
        if (mch_o[g] !== a[g][base[g]]) begin n_fail++; $display("FAIL map%0d_ch addr=%h: got %b want %b", g, a[g], mch_o[g], a[g][base[g]]); end
        if (maddr_o[g] !== a[g]) begin n_fail++; $display("FAIL map%0d_addr: got %h want %h", g, maddr_o[g], a[g]); end
      end
    end
    for (int g = 0; g < 3; g++) mv_i[g] = 1'b0;
  endtask

  task automatic test_credit_stall();
    logic [nc-1:0] exp [9] = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0000};
    int rsp [9] = '{-1, -1, 1, -1, 1, 1, 0, -1, -1};
    v_i = 4'b0011; wnr_i = '0; ready_i = 1'b1;
    addr_i[0] = 21'h0; addr_i[1] = 21'h8;
    for (int c = 0; c < 9; c++) begin
      resp_v_i = rsp[c] >= 0;
      resp_ch_i = rsp[c] == 1;
      #1;
      n_checks++;
      if (yumi_o !== exp[c]) begin n_fail++; $display("FAIL stall_yumi c=%0d: got %b want %b", c, yumi_o, exp[c]); end
      tick();
    end
    v_i = '0;
    for (int c = 0; c < 4; c++) begin
      resp_v_i = 1'b1; resp_ch_i = c >= 2;
      tick();
    end
    resp_v_i = 1'b0;
  endtask

  task automatic test_back_to_back_pressure();
    int w;
    logic [aw-1:0] a_exp;
    v_i = '1; wnr_i = '1; ready_i = 1'b1;
    for (int i = 0; i < nc; i++) addr_i[i] = aw'($urandom);
    w = m_rr;
    a_exp = addr_i[w];
    #1;
    n_checks++;
    if (yumi_o !== nc'(1 << w)) begin n_fail++; $display("FAIL bp_first_yumi: got %b want %b", yumi_o, nc'(1 << w)); end
    tick();
    ready_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < nc; i++) addr_i[i] = aw'($urandom);
      #1;
      n_checks += 4;
      if (yumi_o !== '0) begin n_fail++; $display("FAIL bp_yumi c=%0d: got %b want 0", c, yumi_o); end
      if (v_o !== 1'b1) begin n_fail++; $display("FAIL bp_v c=%0d: got %b want 1", c, v_o); end
      if (client_o !== 2'(w)) begin n_fail++; $display("FAIL bp_client c=%0d: got %0d want %0d", c, client_o, w); end
      if (addr_o !== a_exp) begin n_fail++; $display("FAIL bp_addr c=%0d: got %h want %h", c, addr_o, a_exp); end
      tick();
    end
    ready_i = 1'b1;
    #1;
    n_checks++;
    if (yumi_o !== nc'(1 << ((w + 1) % nc))) begin n_fail++; $display("FAIL bp_resume_yumi: got %b want %b", yumi_o, nc'(1 << ((w + 1) % nc))); end
    tick();
    v_i = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    v_i = 4'b0001; wnr_i = '0; ready_i = 1'b1; addr_i[0] = 21'h10;
    tick();
    ready_i = 1'b0; v_i = '1;
    for (int i = 0; i < nc; i++) addr_i[i] = aw'($urandom) & ~aw'(1 << bo);
    #2 reset_i = 1'b1;
    #1;
    n_checks += 3;
    if (v_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_v: got %b want 0", v_o); end
    if (yumi_o !== '0) begin n_fail++; $display("FAIL rstmid_yumi: got %b want 0", yumi_o); end
    if (addr_o !== '0) begin n_fail++; $display("FAIL rstmid_addr: got %h want 0", addr_o); end
    tick();
    reset_i = 1'b0; ready_i = 1'b1;
    #1;
    n_checks++;
    if (yumi_o !== 4'b0001) begin n_fail++; $display("FAIL rstmid_first: got %b want 0001", yumi_o); end
    tick();
    n_checks += 2;
    if (yumi_o !== 4'b0010) begin n_fail++; $display("FAIL rstmid_second: got %b want 0010", yumi_o); end
    if (client_o !== 2'd0) begin n_fail++; $display("FAIL rstmid_client: got %0d want 0", client_o); end
    tick();
    n_checks++;
    if (yumi_o !== 4'b0000) begin n_fail++; $display("FAIL rstmid_credit: got %b want 0000", yumi_o); end
    v_i = '0;
    tick();
    for (int c = 0; c < 2; c++) begin resp_v_i = 1'b1; resp_ch_i = 1'b0; tick(); end
    resp_v_i = 1'b0;
  endtask

  task automatic test_random();
    int c;
    for (int n = 0; n < 300; n++) begin
      v_i = nc'($urandom); wnr_i = nc'($urandom); ready_i = ($urandom % 4) != 0;
      for (int i = 0; i < nc; i++) begin addr_i[i] = aw'($urandom); data_i[i] = {$urandom, $urandom}; end
      c = $urandom % 2;
      resp_ch_i = c[0];
      resp_v_i = m_cnt[c] > 0 && ($urandom % 2) == 1;
      #1;
      n_checks += 2;
      if (yumi_o !== m_yumi()) begin n_fail++; $display("FAIL rand_yumi n=%0d: got %b want %b", n, yumi_o, m_yumi()); end
      if (v_o !== m_v) begin n_fail++; $display("FAIL rand_v n=%0d: got %b want %b", n, v_o, m_v); end
      if (m_v) begin
        n_checks += 5;
        if (client_o !== 2'(m_client)) begin n_fail++; $display("FAIL rand_client n=%0d: got %0d want %0d", n, client_o, m_client); end
        if (ch_o !== m_ch) begin n_fail++; $display("FAIL rand_ch n=%0d: got %b want %b", n, ch_o, m_ch); end
        if (addr_o !== m_addr) begin n_fail++; $display("FAIL rand_addr n=%0d: got %h want %h", n, addr_o, m_addr); end
        if (wnr_o !== m_wnr) begin n_fail++; $display("FAIL rand_wnr n=%0d: got %b want %b", n, wnr_o, m_wnr); end
        if (data_o !== m_data) begin n_fail++; $display("FAIL rand_data n=%0d: got %h want %h", n, data_o, m_data); end
      end
      tick();
    end
    v_i = '0; ready_i = 1'b1;
    for (int n = 0; n < 8; n++) begin
      resp_v_i = m_cnt[0] > 0 || m_cnt[1] > 0;
      resp_ch_i = m_cnt[0] == 0;
      tick();
    end
    resp_v_i = 1'b0;
  endtask

  initial begin
    for (int g = 0; g < 3; g++) begin mv_i[g] = 1'b0; maddr_i[g] = '0; end
    test_reset();
    test_fairness();
    test_decode();
    test_credit_stall();
    test_back_to_back_pressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
